// File: rtl/apb_master_arb.sv
// Two-requester APB master: arbitrates req0/req1, runs SETUP/ACCESS/CAPTURE, returns done and read data.
// Optional feature: define APB_RR_EN for round-robin arbitration (default build is fixed priority, req0 first).
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

module apb_master_arb #(
  parameter int unsigned ACC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [`addrWidth-1:0] req0_addr,
  input  logic [`dataWidth-1:0] req0_wdata,
  input  logic                  req0_write,
  output logic                  req0_ack,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic [`addrWidth-1:0] req1_addr,
  input  logic [`dataWidth-1:0] req1_wdata,
  input  logic                  req1_write,
  output logic                  req1_ack,
  output logic                  req1_done,
  output logic [`dataWidth-1:0] rdata,
  output logic [`addrWidth-1:0] paddr,
  output logic [`dataWidth-1:0] pwdata,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  input  logic [`dataWidth-1:0] prdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_q;
  logic             gnt_d;
  logic             grant_c;

`ifdef APB_RR_EN
  logic             last_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, arbitration and the same-cycle ack pulse
  always_comb begin
    state_d  = state_q;
    grant_c  = 1'b0;
    gnt_d    = 1'b0;
    req0_ack = 1'b0;
    req1_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          grant_c = 1'b1;
`ifdef APB_RR_EN
          if (req0_valid && req1_valid) begin
            gnt_d = ~last_q;
          end else begin
            gnt_d = req1_valid;
          end
`else
          gnt_d = ~req0_valid;
`endif
          req0_ack = ~gnt_d;
          req1_ack = gnt_d;
          state_d  = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (cnt_q == CNT_LAST) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // APB bus registers, access counter, completion and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rdata     <= '0;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
    end else begin
      psel      <= (state_d == SETUP) || (state_d == ACCESS);
      penable   <= (state_d == ACCESS);
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      if (grant_c) begin
        paddr  <= gnt_d ? req1_addr  : req0_addr;
        pwdata <= gnt_d ? req1_wdata : req0_wdata;
        pwrite <= gnt_d ? req1_write : req0_write;
        gnt_q  <= gnt_d;
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == CAPTURE) begin
        if (!pwrite) rdata <= prdata;
        req0_done <= ~gnt_q;
        req1_done <= gnt_q;
      end
    end
  end

`ifdef APB_RR_EN
  // Last-granted requester, consulted only on simultaneous requests
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant_c) begin
      last_q <= gnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: random requesters, cycle-count reference model, directed arbitration and reset cases.
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef dataWidth
`define dataWidth 32
`endif

module tb_apb_master_arb;

  parameter int unsigned ACC_CYCLES = 1;
  localparam int AW  = `addrWidth;
  localparam int DW  = `dataWidth;
  localparam int ACC = int'(ACC_CYCLES);

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_write, req1_write;
  logic          req0_ack, req1_ack, req0_done, req1_done;
  logic [DW-1:0] rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;

  always #5 clk = ~clk;

  apb_master_arb #(.ACC_CYCLES(ACC_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_write(req0_write), .req0_ack(req0_ack), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_write(req1_write), .req1_ack(req1_ack), .req1_done(req1_done),
    .rdata(rdata), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata)
  );

  // Peripheral: read data is a fixed function of the address
  function automatic logic [DW-1:0] prd_f(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(32'h5AC3_3CA5);
  endfunction
  assign prdata = prd_f(paddr);

  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    int            start;
  } xfer_t;

  xfer_t         sb[$];
  int            gseq[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            free_at = 0;
  int            mode = 1;
  bit            armed = 0;
  bit            rec_on = 0;
  logic          rst_edge = 1'b0;
  logic          last = 1'b1;
  logic [DW-1:0] exp_rdata = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s cycle %0d: timed out", nm, cyc);
  endtask

  // Requester behaviour: hold until ack, then new request or drop; occasionally withdraw
  task automatic next_req(input logic acked, input logic v, output logic nv, output logic fresh);
    nv    = v;
    fresh = 1'b0;
    if (mode == 2) begin
      nv = 1'b0;
    end else if (mode == 1) begin
      nv    = 1'b1;
      fresh = acked || !v;
    end else if (acked || !v) begin
      nv    = ($urandom_range(0, 2) != 0);
      fresh = nv;
    end else if ($urandom_range(0, 9) == 0) begin
      nv = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'(32'h8000_0000);
    return AW'($urandom);
  endfunction

  initial begin : driver
    logic a0, a1, nv, fr;
    req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_write = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_write = 1'b0;
    forever begin
      @(negedge clk);
      a0 = req0_ack;
      a1 = req1_ack;
      @(posedge clk);
      #1;
      next_req(a0, req0_valid, nv, fr);
      req0_valid = nv;
      if (fr) begin
        req0_addr = rnd_addr(); req0_wdata = DW'($urandom); req0_write = 1'($urandom_range(0, 1));
      end
      next_req(a1, req1_valid, nv, fr);
      req1_valid = nv;
      if (fr) begin
        req1_addr = rnd_addr(); req1_wdata = DW'($urandom); req1_write = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : edge_sampler
    forever begin
      @(posedge clk);
      rst_edge = reset;
    end
  end

  // Monitor and reference model: one transfer in flight, timing by cycle arithmetic
  initial begin : monitor
    logic [1:0] exp_done, exp_ack;
    logic       exp_ps, exp_pe, g;
    xfer_t      f, n;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_edge) armed = 1'b1;
      if (armed) begin
        exp_done = 2'b00; exp_ack = 2'b00; exp_ps = 1'b0; exp_pe = 1'b0;
        if (rst_edge) begin
          sb.delete();
          free_at   = cyc;
          exp_rdata = '0;
          last      = 1'b1;
          chk("reset_state", 128'({paddr, pwdata, pwrite, rdata}), 128'(0));
        end
        if (sb.size() > 0) begin
          f = sb[0];
          if (cyc == f.start + 3 + ACC) begin
            exp_done[f.id] = 1'b1;
            if (!f.wr) exp_rdata = prd_f(f.addr);
            chk("rdata", 128'(rdata), 128'(exp_rdata));
            void'(sb.pop_front());
          end else begin
            exp_ps = (cyc >= f.start + 1) && (cyc <= f.start + 1 + ACC);
            exp_pe = (cyc >= f.start + 2) && (cyc <= f.start + 1 + ACC);
            if (cyc >= f.start + 1)
              chk("apb_fields", 128'({paddr, pwdata, pwrite}), 128'({f.addr, f.wdata, f.wr}));
          end
        end
        chk("done", 128'({req1_done, req0_done}), 128'(exp_done));
        chk("psel_penable", 128'({psel, penable}), 128'({exp_ps, exp_pe}));
        if (!reset && cyc >= free_at && (req0_valid || req1_valid)) begin
`ifdef APB_RR_EN
          g = (req0_valid && req1_valid) ? !last : req1_valid;
`else
          g = !req0_valid;
`endif
          last       = g;
          exp_ack[g] = 1'b1;
          n.id    = g;
          n.addr  = g ? req1_addr  : req0_addr;
          n.wdata = g ? req1_wdata : req0_wdata;
          n.wr    = g ? req1_write : req0_write;
          n.start = cyc;
          sb.push_back(n);
          free_at = cyc + 3 + ACC;
        end
        chk("ack", 128'({req1_ack, req0_ack}), 128'(exp_ack));
        if (rec_on) begin
          if (req0_ack) gseq.push_back(0);
          if (req1_ack) gseq.push_back(1);
        end
      end
    end
  end

  initial begin : main
    int exp_g[4];
    bit found;
`ifdef APB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    reset = 1'b1;
    mode  = 1;
    repeat (3) @(posedge clk);
    #1 rec_on = 1'b1;
    reset = 1'b0;

    // Both requesters asserted continuously from reset
    for (int i = 0; i < 100 && gseq.size() < 4; i++) @(negedge clk);
    rec_on = 1'b0;
    if (gseq.size() < 4) fail_now("grant_order");
    else for (int i = 0; i < 4; i++) chk("grant_order", 128'(gseq[i]), 128'(exp_g[i]));

    mode = 0;
    repeat (400) @(posedge clk);

    // Reset pulse landing on an ACCESS cycle
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = psel && penable;
    end
    if (!found) fail_now("find_access");
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    repeat (300) @(posedge clk);
    mode = 2;
    repeat (30) @(negedge clk);
    chk("drained", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 The block SHALL have parameter ACC_CYCLES, default 1, giving the number of ACCESS cycles (penable high) per transfer, legal range 1..15.
REQ-002 The block SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, in, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, in, 1, each a transfer request held high until acked.
REQ-005 The block SHALL have ports req0_addr / req1_addr, in, `addrWidth, each the transfer address.
REQ-006 The block SHALL have ports req0_wdata / req1_wdata, in, `dataWidth, each the write data.
REQ-007 The block SHALL have ports req0_write / req1_write, in, 1, each 1 for write and 0 for read.
REQ-008 The block SHALL have ports req0_ack / req1_ack, out, 1, each a one-cycle pulse meaning request accepted and fields latched.
REQ-009 The block SHALL have ports req0_done / req1_done, out, 1, each a one-cycle pulse meaning transfer complete.
REQ-010 The block SHALL have port rdata, out, `dataWidth, read data, valid while a done pulse is high for a read.
REQ-011 The block SHALL have ports paddr (out, `addrWidth), pwdata (out, `dataWidth), pwrite (out, 1), psel (out, 1) and penable (out, 1), the APB master outputs, all registered.
REQ-012 The block SHALL have port prdata, in, `dataWidth, the APB read data from the peripheral.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, ACCESS and CAPTURE.
REQ-014 In IDLE with any valid high, the block SHALL grant one requester, pulse its ack that cycle, latch addr/wdata/write into the bus registers and go to SETUP.
REQ-015 In SETUP the block SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-016 In ACCESS the block SHALL drive psel=1 and penable=1 for ACC_CYCLES cycles, counted by a 4-bit counter, then go to CAPTURE.
REQ-017 In CAPTURE the block SHALL drive psel=0 and penable=0, register prdata into rdata, go to IDLE, and assert the granted requester's done on the following cycle.
REQ-018 paddr, pwdata and pwrite SHALL hold stable from SETUP through CAPTURE.
REQ-019 Latency: valid sampled in IDLE at cycle T gives SETUP at T+1, done at T+3+ACC_CYCLES (T+4 for default).
REQ-020 In the IDLE cycle where done pulses, a new grant SHALL be allowed, giving back-to-back transfers every 3+ACC_CYCLES cycles.
REQ-021 Valid inputs outside IDLE SHALL be ignored; no ack is issued until the next IDLE.
REQ-022 Valid dropped by a requester before its ack SHALL withdraw that request without error.
REQ-023 At most one ack and at most one done SHALL be high in any cycle.
REQ-024 On a write transfer, rdata SHALL hold its previous value.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL enter IDLE and clear psel, penable, pwrite, paddr, pwdata, rdata, acks, dones, the ACCESS counter, and set the last-grant pointer to 1.
REQ-026 Reset mid-transfer SHALL abort it: psel and penable SHALL be low after the edge, and no done SHALL be issued for the aborted transfer.

Configuration
REQ-027 With APB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous valids, the requester not granted last wins, and the pointer updates on every grant.
REQ-028 With APB_RR_EN undefined, arbitration SHALL be fixed priority with req0 always winning, and the pointer SHALL be unused.

Verification
REQ-029 Scenario: req0 read of addr 0x80000000 with prdata=0xA5A5A5A5 -> ack0 at T, psel at T+1, penable at T+2, done0 at T+4 with rdata=0xA5A5A5A5.
REQ-030 Scenario: req1 write of 0x12345678 to 0x80000000 -> paddr, pwdata and pwrite=1 stable from T+1 to T+3, done1 at T+4, rdata unchanged.
REQ-031 Scenario: both valid continuously for 4 transfers -> grants 0,1,0,1 with APB_RR_EN defined, and 0,0,0,0 without it.
REQ-032 Scenario: ACC_CYCLES=3 with a single read -> penable high for exactly 3 cycles, done at T+6.
REQ-033 Scenario: reset pulsed during ACCESS -> psel=penable=0 next cycle, no done, and the next request is granted normally afterwards.
REQ-034 Scenario: req0 valid dropped before ack, during a req1 transfer -> no ack0, no APB cycle for req0.
